// File: rtl/irq_pkg.sv
// Shared register offsets, FSM state encodings and ID constants for the irq_hub block.
package irq_pkg;

    localparam logic [1:0] IRQ_REG_PENDING  = 2'd0;
    localparam logic [1:0] IRQ_REG_ENABLE   = 2'd1;
    localparam logic [1:0] IRQ_REG_CLAIM    = 2'd2;
    localparam logic [1:0] IRQ_REG_COMPLETE = 2'd3;

    localparam int ID_NONE = 0;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_ASSERT  = 2'd1,
        IRQ_CLAIMED = 2'd2,
        IRQ_GAP     = 2'd3
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins; reports it as ID (index+1) and as a one-hot mask.
module irq_prio_enc #(
    parameter int N_SRC = 4,
    parameter int ID_W  = 5
) (
    input  logic [N_SRC-1:0] vec,
    output logic             valid,
    output logic [ID_W-1:0]  id,
    output logic [N_SRC-1:0] onehot
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        valid  = 1'b0;
        id     = '0;
        onehot = '0;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                valid     = 1'b1;
                id        = ID_W'(i + 1);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_hub.sv
// Interrupt aggregator driving the m_eip/m_eip_reply handshake, with a 4-word register window.
// Optional build macro IRQ_HUB_LEVEL_EN: level-sensitive sources, pending mirrors irq.
module irq_hub
    import irq_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int ID_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       a,
    input  logic [31:0]      d,
    input  logic             we,
    output logic [31:0]      spo,
    input  logic [N_SRC-1:0] irq,
    output logic             m_eip,
    input  logic             m_eip_reply,
    output logic             busy
);

    irq_state_e       state;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] enable;
    logic [ID_W-1:0]  claim_id;

    logic             sel_valid;
    logic [ID_W-1:0]  sel_id;
    logic [N_SRC-1:0] sel_onehot;
    logic             claim_fire;
    logic             wr_pending;
    logic             wr_enable;
    logic             wr_complete;

    assign wr_pending  = we && (a == IRQ_REG_PENDING);
    assign wr_enable   = we && (a == IRQ_REG_ENABLE);
    assign wr_complete = we && (a == IRQ_REG_COMPLETE);
    assign claim_fire  = (state == IRQ_ASSERT) && m_eip_reply && sel_valid;

    irq_prio_enc #(
        .N_SRC(N_SRC),
        .ID_W (ID_W)
    ) u_prio_enc (
        .vec   (pending & enable),
        .valid (sel_valid),
        .id    (sel_id),
        .onehot(sel_onehot)
    );

`ifdef IRQ_HUB_LEVEL_EN
    logic unused_level;
    assign unused_level = ^{d[31:N_SRC], wr_pending, sel_onehot};

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) pending <= '0;
        else     pending <= irq;
    end
`else
    logic             unused_d;
    logic [N_SRC-1:0] pending_clr;
    logic [N_SRC-1:0] pending_next;

    assign unused_d = ^d[31:N_SRC];

    always_comb begin
        pending_clr = '0;
        if (wr_pending) pending_clr = d[N_SRC-1:0];
        if (claim_fire) pending_clr = pending_clr | sel_onehot;
        // New pulses are OR-ed in after the clear, so a same-cycle set beats W1C.
        pending_next = (pending & ~pending_clr) | irq;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) pending <= '0;
        else     pending <= pending_next;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst)            enable <= '0;
        else if (wr_enable) enable <= d[N_SRC-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IRQ_IDLE;
            m_eip    <= 1'b0;
            busy     <= 1'b0;
            claim_id <= ID_W'(ID_NONE);
        end else begin
            case (state)
                IRQ_IDLE: begin
                    if (sel_valid) begin
                        state <= IRQ_ASSERT;
                        m_eip <= 1'b1;
                    end
                end
                IRQ_ASSERT: begin
                    if (claim_fire) begin
                        state    <= IRQ_CLAIMED;
                        m_eip    <= 1'b0;
                        busy     <= 1'b1;
                        claim_id <= sel_id;
                    end else if (!sel_valid) begin
                        state <= IRQ_IDLE;
                        m_eip <= 1'b0;
                    end
                end
                IRQ_CLAIMED: begin
                    if (wr_complete && (d[ID_W-1:0] == claim_id)) begin
                        state    <= IRQ_GAP;
                        busy     <= 1'b0;
                        claim_id <= ID_W'(ID_NONE);
                    end
                end
                IRQ_GAP: begin
                    // Guarantees m_eip stays low for at least two cycles between requests.
                    state <= IRQ_IDLE;
                end
                default: begin
                    state <= IRQ_IDLE;
                    m_eip <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        spo = '0;
        case (a)
            IRQ_REG_PENDING: spo = 32'(pending);
            IRQ_REG_ENABLE:  spo = 32'(enable);
            IRQ_REG_CLAIM:   spo = 32'(claim_id);
            default:         spo = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_hub.sv
// Self-checking bench for irq_hub: expected claim IDs are queued when stimulus is driven, popped at each claim.
module tb_irq_hub;

    localparam int N_SRC = 4;
    localparam int ID_W  = 5;

    logic             clk;
    logic             rst;
    logic [1:0]       a;
    logic [31:0]      d;
    logic             we;
    logic [31:0]      spo;
    logic [N_SRC-1:0] irq;
    logic             m_eip;
    logic             m_eip_reply;
    logic             busy;

    int checks;
    int failures;
    int exp_claims[$];

    irq_hub #(
        .N_SRC(N_SRC),
        .ID_W (ID_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .d          (d),
        .we         (we),
        .spo        (spo),
        .irq        (irq),
        .m_eip      (m_eip),
        .m_eip_reply(m_eip_reply),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [1:0] addr, input logic [31:0] data);
        a    = addr;
        d    = data;
        we   = 1'b1;
        tick();
        we   = 1'b0;
        d    = '0;
    endtask

    task automatic read_reg(input logic [1:0] addr, output logic [31:0] data);
        a = addr;
        #1;
        data = spo;
    endtask

    task automatic pulse_irq(input logic [N_SRC-1:0] v);
        irq = v;
        tick();
        irq = '0;
    endtask

    task automatic reply();
        m_eip_reply = 1'b1;
        tick();
        m_eip_reply = 1'b0;
    endtask

    task automatic wait_eip(input string tag);
        int n;
        n = 0;
        while (m_eip !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check(tag, 32'(m_eip), 32'd1);
    endtask

    task automatic check_claim(input string tag);
        logic [31:0] got;
        logic [31:0] exp;
        exp = (exp_claims.size() > 0) ? 32'(exp_claims.pop_front()) : 32'hFFFF_FFFF;
        read_reg(2'd2, got);
        check(tag, got, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [31:0] rd;

    initial begin
        checks = 0;
        failures = 0;
        a = '0; d = '0; we = 1'b0; irq = '0; m_eip_reply = 1'b0;
        do_reset();

        check("reset_m_eip", 32'(m_eip), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        read_reg(2'd0, rd); check("reset_pending", rd, 32'd0);
        read_reg(2'd1, rd); check("reset_enable", rd, 32'd0);
        read_reg(2'd2, rd); check("reset_claim", rd, 32'd0);
        read_reg(2'd3, rd); check("complete_reads_0", rd, 32'd0);

`ifdef IRQ_HUB_LEVEL_EN
        write_reg(2'd1, 32'h1);
        irq = 4'b0001;
        exp_claims.push_back(1);
        wait_eip("lvl_first_eip");
        reply();
        check("lvl_busy", 32'(busy), 32'd1);
        check_claim("lvl_claim");
        read_reg(2'd0, rd); check("lvl_pending_kept", rd, 32'd1);
        write_reg(2'd0, 32'h1);
        tick();
        read_reg(2'd0, rd); check("lvl_w1c_noop", rd, 32'd1);
        write_reg(2'd3, 32'd1);
        check("lvl_gap_low", 32'(m_eip), 32'd0);
        exp_claims.push_back(1);
        wait_eip("lvl_reassert");
        reply();
        check_claim("lvl_claim2");
        irq = '0;
        tick();
        tick();
        write_reg(2'd3, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("lvl_quiet", 32'(m_eip), 32'd0);
        end
`else
        // Enable mask 0110 with upper write bits ignored.
        write_reg(2'd1, 32'hFFFF_FFF6);
        read_reg(2'd1, rd); check("enable_upper_ignored", rd, 32'd6);

        // irq[2] at T: pending at T+1, m_eip at T+2, reply at T+5.
        exp_claims.push_back(3);
        pulse_irq(4'b0100);
        check("lat_t1_eip_low", 32'(m_eip), 32'd0);
        read_reg(2'd0, rd); check("lat_t1_pending", rd, 32'd4);
        tick();
        check("lat_t2_eip_high", 32'(m_eip), 32'd1);
        tick();
        tick();
        tick();
        check("lat_t5_eip_held", 32'(m_eip), 32'd1);
        reply();
        check("claim_eip_drop", 32'(m_eip), 32'd0);
        check("claim_busy", 32'(busy), 32'd1);
        read_reg(2'd0, rd); check("claim_pending_clr", rd, 32'd0);
        check_claim("claim_id3");

        // Re-pulse of the claimed source is held pending and served after complete.
        exp_claims.push_back(3);
        pulse_irq(4'b0100);
        tick();
        check("repulse_no_eip", 32'(m_eip), 32'd0);
        read_reg(2'd0, rd); check("repulse_pending", rd, 32'd4);
        write_reg(2'd3, 32'd3);
        check("complete_busy0", 32'(busy), 32'd0);
        wait_eip("repulse_eip");
        reply();
        check_claim("repulse_claim");
        write_reg(2'd3, 32'd3);
        tick();

        // Two sources: lowest index claimed first, the other after complete.
        write_reg(2'd1, 32'hF);
        exp_claims.push_back(2);
        exp_claims.push_back(4);
        pulse_irq(4'b1010);
        wait_eip("multi_eip1");
        reply();
        check_claim("multi_claim2");
        read_reg(2'd0, rd); check("multi_pending_left", rd, 32'd8);
        write_reg(2'd3, 32'd3);
        check("wrong_complete_busy", 32'(busy), 32'd1);
        read_reg(2'd2, rd); check("wrong_complete_id", rd, 32'd2);
        write_reg(2'd3, 32'd2);
        check("complete_busy", 32'(busy), 32'd0);
        check("gap_low_1", 32'(m_eip), 32'd0);
        tick();
        check("gap_low_2", 32'(m_eip), 32'd0);
        wait_eip("multi_eip2");
        reply();
        check_claim("multi_claim4");
        write_reg(2'd3, 32'd4);
        tick();

        // W1C aborts a request before reply; a late reply claims nothing.
        pulse_irq(4'b0001);
        tick();
        check("abort_eip_high", 32'(m_eip), 32'd1);
        write_reg(2'd0, 32'd1);
        read_reg(2'd0, rd); check("abort_pending_clr", rd, 32'd0);
        tick();
        check("abort_eip_low", 32'(m_eip), 32'd0);
        reply();
        check("abort_no_busy", 32'(busy), 32'd0);
        read_reg(2'd2, rd); check("abort_no_claim", rd, 32'd0);

        // Same-cycle set and W1C: set wins; then reset during ASSERT.
        irq = 4'b0010;
        write_reg(2'd0, 32'd2);
        irq = '0;
        read_reg(2'd0, rd); check("set_beats_w1c", rd, 32'd2);
        tick();
        check("rst_pre_eip", 32'(m_eip), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_eip", 32'(m_eip), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        read_reg(2'd0, rd); check("rst_pending", rd, 32'd0);
        read_reg(2'd1, rd); check("rst_enable", rd, 32'd0);
        read_reg(2'd2, rd); check("rst_claim", rd, 32'd0);
        reply();
        check("idle_reply_ignored", 32'(busy), 32'd0);
`endif

        check("sb_drained", 32'(exp_claims.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
